// File: rtl/jacobian_sequencer.sv
// -----------------------------------------------------------------------------
// jacobian_sequencer
//   Builds the 6x6 manipulator Jacobian one column per revolute joint. For each
//   joint it fetches the z axis and origin o from the T-matrix source, forms
//   d = s - o, issues the six cross-product multiplies z x d to the external
//   multiplier lanes, and writes the column {z, z x d} to the Jacobian bank.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a run (sampled only in IDLE)
//   busy, done          : run in progress / one-cycle completion pulse
//   joint, count        : joint being processed / cycle counter for the run
//   s_in                : end-effector position {s2,s1,s0}, latched at start
//   t_req, t_ack        : T-matrix request / source handshake
//   t_z, t_o            : z axis {t22,t12,t02}, origin {t23,t13,t03}
//   mul_valid, mul_a/b  : multiplier lane operands (six lanes of W bits)
//   mul_result          : lane products, MUL_LAT cycles after mul_valid
//   j_we, j_col_idx     : column write strobe / column index
//   j_col               : column {J5..J0}
// -----------------------------------------------------------------------------
module jacobian_sequencer #(
  parameter int JOINTS  = 6,
  parameter int W       = 27,
  parameter int MUL_LAT = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2:0]     joint,
  output logic [8:0]     count,
  input  logic [3*W-1:0] s_in,
  output logic           t_req,
  input  logic           t_ack,
  input  logic [3*W-1:0] t_z,
  input  logic [3*W-1:0] t_o,
  output logic           mul_valid,
  output logic [6*W-1:0] mul_a,
  output logic [6*W-1:0] mul_b,
  input  logic [6*W-1:0] mul_result,
  output logic           j_we,
  output logic [2:0]     j_col_idx,
  output logic [6*W-1:0] j_col
);

  localparam int             WCW        = $clog2(MUL_LAT + 1);
  localparam logic [2:0]     LAST_JOINT = 3'(JOINTS - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MUL_LAT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DIFF  = 3'd2,
    MUL   = 3'd3,
    WAIT  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [3*W-1:0] s_q, s_d;
  logic [3*W-1:0] z_q, z_d;
  logic [3*W-1:0] o_q, o_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]     joint_q, joint_d;
  logic [8:0]     count_q, count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           t_req_q, t_req_d;
  logic           mul_valid_q, mul_valid_d;
  logic [6*W-1:0] mul_a_q, mul_a_d;
  logic [6*W-1:0] mul_b_q, mul_b_d;
  logic           j_we_q, j_we_d;
  logic [2:0]     j_col_idx_q, j_col_idx_d;
  logic [6*W-1:0] j_col_q, j_col_d;

  // Component views of the latched vectors and the multiplier products.
  logic [W-1:0] z0, z1, z2, d0, d1, d2;
  logic [W-1:0] r0, r1, r2, r3, r4, r5;
  logic         busy_now;

  assign z0 = z_q[0*W +: W];
  assign z1 = z_q[1*W +: W];
  assign z2 = z_q[2*W +: W];
  // d = s - o wraps modulo 2^W by construction of the W-bit subtraction.
  assign d0 = s_q[0*W +: W] - o_q[0*W +: W];
  assign d1 = s_q[1*W +: W] - o_q[1*W +: W];
  assign d2 = s_q[2*W +: W] - o_q[2*W +: W];
  assign r0 = mul_result[0*W +: W];
  assign r1 = mul_result[1*W +: W];
  assign r2 = mul_result[2*W +: W];
  assign r3 = mul_result[3*W +: W];
  assign r4 = mul_result[4*W +: W];
  assign r5 = mul_result[5*W +: W];

  assign busy_now = (state_q != IDLE) && (state_q != DONE);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    z_d         = z_q;
    o_d         = o_q;
    wait_cnt_d  = wait_cnt_q;
    joint_d     = joint_q;
    j_col_idx_d = j_col_idx_q;
    j_col_d     = j_col_q;
    mul_a_d     = {(6*W){1'b0}};
    mul_b_d     = {(6*W){1'b0}};

    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = s_in;
          joint_d = 3'd0;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (t_ack) begin
          z_d     = t_z;
          o_d     = t_o;
          state_d = DIFF;
        end else begin
          state_d = REQ;
        end
      end
      DIFF: begin
        // Operands are loaded here so they sit on the lanes during MUL.
        // Lane order, 5..0: z1*d0, z0*d1, z0*d2, z2*d0, z2*d1, z1*d2.
        mul_a_d = {z1, z0, z0, z2, z2, z1};
        mul_b_d = {d0, d1, d2, d0, d1, d2};
        state_d = MUL;
      end
      MUL: begin
        wait_cnt_d = WCW'(1);
        state_d    = WAIT;
      end
      WAIT: begin
        // Last WAIT cycle is exactly MUL_LAT cycles after MUL: products valid.
        if (wait_cnt_q == WAIT_LAST) begin
          j_col_d     = {z2, z1, z0, r4 - r5, r2 - r3, r0 - r1};
          j_col_idx_d = joint_q;
          state_d     = WRITE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
          state_d    = WAIT;
        end
      end
      WRITE: begin
        if (joint_q == LAST_JOINT) begin
          state_d = DONE;
        end else begin
          joint_d = joint_q + 3'd1;
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // count reads 1 in the first busy cycle so it equals cycles since start.
    if ((state_q == IDLE) && start) begin
      count_d = 9'd1;
    end else if (busy_now && (count_q != 9'd511)) begin
      count_d = count_q + 9'd1;
    end else begin
      count_d = count_q;
    end

    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
    t_req_d     = (state_d == REQ);
    mul_valid_d = (state_d == MUL);
    j_we_d      = (state_d == WRITE);
  end

  // State and output registers; reset clears everything and aborts a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= {(3*W){1'b0}};
      z_q         <= {(3*W){1'b0}};
      o_q         <= {(3*W){1'b0}};
      wait_cnt_q  <= {WCW{1'b0}};
      joint_q     <= 3'd0;
      count_q     <= 9'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      t_req_q     <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= {(6*W){1'b0}};
      mul_b_q     <= {(6*W){1'b0}};
      j_we_q      <= 1'b0;
      j_col_idx_q <= 3'd0;
      j_col_q     <= {(6*W){1'b0}};
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      z_q         <= z_d;
      o_q         <= o_d;
      wait_cnt_q  <= wait_cnt_d;
      joint_q     <= joint_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      t_req_q     <= t_req_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      j_we_q      <= j_we_d;
      j_col_idx_q <= j_col_idx_d;
      j_col_q     <= j_col_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign joint     = joint_q;
  assign count     = count_q;
  assign t_req     = t_req_q;
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign j_we      = j_we_q;
  assign j_col_idx = j_col_idx_q;
  assign j_col     = j_col_q;

endmodule

// File: tb/tb_jacobian_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jacobian_sequencer
//   Scoreboard bench: the T-matrix source model pushes the expected Jacobian
//   column (cross product computed arithmetically) and its write cycle when it
//   acknowledges a request; a negedge monitor pops and compares on j_we/done.
//   The external multiplier is modelled as a MUL_LAT-deep pipeline that emits
//   random garbage whenever no valid operands were issued.
// -----------------------------------------------------------------------------
module tb_jacobian_sequencer;

  localparam int JOINTS  = 6;
  localparam int W       = 27;
  localparam int MUL_LAT = 5;
  localparam int PERIOD  = 4 + MUL_LAT;

  logic           clk = 1'b0;
  logic           reset, start;
  logic           busy, done, t_req, t_ack, mul_valid, j_we;
  logic [2:0]     joint, j_col_idx;
  logic [8:0]     count;
  logic [3*W-1:0] s_in, t_z, t_o;
  logic [6*W-1:0] mul_a, mul_b, mul_result, j_col;

  jacobian_sequencer #(.JOINTS(JOINTS), .W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .joint(joint), .count(count), .s_in(s_in), .t_req(t_req), .t_ack(t_ack),
    .t_z(t_z), .t_o(t_o), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .j_we(j_we), .j_col_idx(j_col_idx), .j_col(j_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [6*W-1:0] col; int cyc; } wr_t;
  typedef struct { int cyc; int cnt; } dn_t;
  wr_t exp_q[$];
  dn_t done_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [3*W-1:0] tz [8];
  logic [3*W-1:0] to_ [8];
  logic [3*W-1:0] s_run;
  int             dly [8];
  int             drv_k;
  bit             drv_in_req;
  int             drv_wait;
  bit             spurious_en;
  bit             dir_en, lane_chk_en;
  logic [6*W-1:0] dir_col, dir_lanes, last_exp_col;

  function automatic logic [W-1:0] rnd_w();
    return W'($urandom());
  endfunction

  function automatic logic [3*W-1:0] rnd3();
    return {rnd_w(), rnd_w(), rnd_w()};
  endfunction

  // Reference column: (z x (s - o), z), all arithmetic mod 2^W.
  function automatic logic [6*W-1:0] ref_col(input logic [3*W-1:0] z, input logic [3*W-1:0] o,
                                             input logic [3*W-1:0] s);
    logic [W-1:0] zz [3];
    logic [W-1:0] d  [3];
    logic [W-1:0] c  [3];
    for (int i = 0; i < 3; i++) begin
      zz[i] = z[i*W +: W];
      d[i]  = s[i*W +: W] - o[i*W +: W];
    end
    c[0] = zz[1] * d[2] - zz[2] * d[1];
    c[1] = zz[2] * d[0] - zz[0] * d[2];
    c[2] = zz[0] * d[1] - zz[1] * d[0];
    return {zz[2], zz[1], zz[0], c[2], c[1], c[0]};
  endfunction

  function automatic logic [6*W-1:0] lane_prod(input logic [6*W-1:0] a, input logic [6*W-1:0] b);
    logic [6*W-1:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) p[i*W +: W] = a[i*W +: W] * b[i*W +: W];
    return p;
  endfunction

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_v(input string name, input logic [6*W-1:0] act, input logic [6*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External multiplier: fixed latency, garbage when nothing was issued.
  logic [6*W-1:0] pipe [MUL_LAT];
  always @(posedge clk) begin
    for (int i = MUL_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mul_valid ? lane_prod(mul_a, mul_b) : {rnd3(), rnd3()};
  end
  assign mul_result = pipe[MUL_LAT-1];

  // T-matrix source: answers requests after a per-joint delay and records
  // the column it expects to see written.
  initial begin
    t_ack = 1'b0;
    t_z   = '0;
    t_o   = '0;
    forever begin
      @(negedge clk);
      t_z   = rnd3();
      t_o   = rnd3();
      t_ack = 1'b0;
      if (t_req && !reset) begin
        if (!drv_in_req) begin
          drv_in_req = 1'b1;
          drv_wait   = dly[drv_k % 8];
        end
        if (drv_wait > 0) begin
          drv_wait--;
        end else begin
          t_ack = 1'b1;
          t_z   = tz[drv_k % 8];
          t_o   = to_[drv_k % 8];
          exp_q.push_back('{drv_k, ref_col(tz[drv_k % 8], to_[drv_k % 8], s_run), cyc + 3 + MUL_LAT});
          drv_k++;
          drv_in_req = 1'b0;
        end
      end else if (spurious_en) begin
        t_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares every write, done pulse and idle multiplier bus.
  always @(negedge clk) begin
    wr_t e;
    dn_t d;
    if (j_we) begin
      if (exp_q.size() == 0) begin
        check_i("unexpected_write", int'(j_we), 0);
      end else begin
        e = exp_q.pop_front();
        check_i("col_idx", int'(j_col_idx), e.idx);
        check_v("col", j_col, e.col);
        check_i("write_cycle", cyc, e.cyc);
        check_i("busy_in_write", int'(busy), 1);
        last_exp_col = e.col;
        if (dir_en && e.idx == 0) begin
          check_v("directed_col", j_col, dir_col);
          dir_en = 1'b0;
        end
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check_i("unexpected_done", int'(done), 0);
      end else begin
        d = done_q.pop_front();
        check_i("done_cycle", cyc, d.cyc);
        check_i("done_count", int'(count), d.cnt);
        check_i("busy_at_done", int'(busy), 0);
      end
      done_cnt++;
    end
    if (mul_valid) begin
      if (lane_chk_en) begin
        check_v("lane_products", lane_prod(mul_a, mul_b), dir_lanes);
        lane_chk_en = 1'b0;
      end
    end else begin
      check_v("mul_a_idle", mul_a, '0);
      check_v("mul_b_idle", mul_b, '0);
    end
  end

  task automatic check_all_zero(input string tag);
    check_i({tag, "_busy"}, int'(busy), 0);
    check_i({tag, "_done"}, int'(done), 0);
    check_i({tag, "_joint"}, int'(joint), 0);
    check_i({tag, "_count"}, int'(count), 0);
    check_i({tag, "_t_req"}, int'(t_req), 0);
    check_i({tag, "_mul_valid"}, int'(mul_valid), 0);
    check_i({tag, "_j_we"}, int'(j_we), 0);
    check_i({tag, "_j_col_idx"}, int'(j_col_idx), 0);
    check_v({tag, "_mul_a"}, mul_a, '0);
    check_v({tag, "_mul_b"}, mul_b, '0);
    check_v({tag, "_j_col"}, j_col, '0);
  endtask

  task automatic randomize_joints();
    for (int k = 0; k < 8; k++) begin
      tz[k]  = rnd3();
      to_[k] = rnd3();
      dly[k] = 0;
    end
    s_run = rnd3();
  endtask

  // One full run started at the current negedge; expectations come from
  // the column period and any inserted acknowledge delays.
  task automatic do_run(input bit pulse_start);
    int c, extra, n0, exp_done, exp_cnt;
    extra = 0;
    for (int k = 0; k < JOINTS; k++) extra += dly[k];
    c        = cyc;
    exp_done = c + 1 + JOINTS * PERIOD + extra;
    exp_cnt  = (exp_done - c > 511) ? 511 : exp_done - c;
    done_q.push_back('{exp_done, exp_cnt});
    s_in       = s_run;
    start      = 1'b1;
    drv_k      = 0;
    drv_in_req = 1'b0;
    n0         = done_cnt;
    @(negedge clk);
    start = 1'b0;
    check_i("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 400 && done_cnt == n0; i++) begin
      s_in  = rnd3();
      start = pulse_start && (i % 7 == 3) && (i < 45);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_cnt == n0) begin
      errors++;
      $display("FAIL done_timeout: got no done, expected at cycle %0d", exp_done);
    end
    repeat (3) @(negedge clk);
    check_i("count_hold", int'(count), exp_cnt);
    check_i("joint_hold", int'(joint), JOINTS - 1);
    check_i("busy_idle", int'(busy), 0);
    check_v("col_hold", j_col, last_exp_col);
    check_i("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int c;
    reset       = 1'b1;
    start       = 1'b0;
    s_in        = '0;
    spurious_en = 1'b0;
    dir_en      = 1'b0;
    lane_chk_en = 1'b0;
    drv_k       = 0;
    drv_in_req  = 1'b0;
    drv_wait    = 0;
    randomize_joints();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed single column on joint 0, clean full run.
    randomize_joints();
    tz[0]     = {W'(1), W'(0), W'(0)};
    to_[0]    = {W'(0), W'(1), W'(1)};
    s_run     = {W'(0), W'(4), W'(3)};
    dir_col   = {W'(1), W'(0), W'(0), W'(0), W'(2), W'(27'h7FFFFFD)};
    dir_lanes = {W'(0), W'(0), W'(0), W'(2), W'(3), W'(0)};
    dir_en      = 1'b1;
    lane_chk_en = 1'b1;
    do_run(1'b0);
    check_i("dir_col_seen", int'(dir_en), 0);
    check_i("lanes_seen", int'(lane_chk_en), 0);

    // Wrap case on joint 0 plus a 3-cycle acknowledge delay on joint 2.
    randomize_joints();
    tz[0]   = {W'(1), W'(0), W'(0)};
    to_[0]  = {W'(0), W'(0), W'(27'h4000000)};
    s_run   = {W'(0), W'(0), W'(27'h3FFFFFF)};
    dir_col = {W'(1), W'(0), W'(0), W'(0), W'(27'h7FFFFFF), W'(0)};
    dir_en  = 1'b1;
    dly[2]  = 3;
    do_run(1'b0);

    // Random data with start pulses while busy and spurious acknowledges.
    randomize_joints();
    spurious_en = 1'b1;
    do_run(1'b1);
    spurious_en = 1'b0;

    // Reset during WAIT of joint 3: run aborts silently.
    randomize_joints();
    c          = cyc;
    s_in       = s_run;
    start      = 1'b1;
    drv_k      = 0;
    drv_in_req = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 3 * PERIOD + 5) begin
      s_in = rnd3();
      @(negedge clk);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Clean random run after the abort.
    randomize_joints();
    do_run(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
